alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//   Upstream command stage for the 16-bit ALU units (arithmetic, logic, compare, shift).
//   Accepts ALU commands on a valid/ready interface and buffers them in a DEPTH-entry FIFO.
//   Decodes each command into a unit enable plus a 2-bit unit opcode, issues one command at a time,
//   then waits for that unit's flag before issuing the next.
// PARAMETERS
//   Width    16   operand width (A/B datapath)
//   DEPTH    4    command FIFO entries; power of 2, >=2
//   TIMEOUT  8    max cycles in WAIT for Unit_Flag before error; >=2
// PORTS
//   CLK           in   1       clock, all logic on rising edge
//   RST           in   1       synchronous, active-high reset
//   IN_Valid      in   1       command valid
//   IN_Ready      out  1       FIFO can accept (count < DEPTH)
//   IN_A          in   Width   operand A
//   IN_B          in   Width   operand B
//   IN_FUN        in   4       [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] unit op
//   A             out  Width   operand A to units
//   B             out  Width   operand B to units
//   ALU_FUN       out  2       unit opcode (IN_FUN[1:0] of issued command)
//   Arith_Enable  out  1       one-cycle issue pulse, arithmetic unit
//   Logic_Enable  out  1       one-cycle issue pulse, logic unit
//   CMP_Enable    out  1       one-cycle issue pulse, compare unit
//   Shift_Enable  out  1       one-cycle issue pulse, shift unit
//   Unit_Flag     in   1       OR of unit flags; high the cycle after the unit samples its enable
//   Op_Done       out  1       one-cycle pulse, issued command completed
//   Timeout_Err   out  1       sticky; set on WAIT timeout
//   Busy          out  1       FIFO non-empty or state != IDLE
// BEHAVIOUR
//   Reset: all outputs 0 except IN_Ready=1. FIFO empty, state IDLE, timeout counter 0.
//   Reset mid-operation: flush FIFO and drop the in-flight command. Unit_Flag is ignored in reset.
//   Push: occurs when IN_Valid && IN_Ready at a clock edge.
//     IN_Ready depends only on the current count; a same-cycle pop does not raise it.
//   Pop: occurs in IDLE when the FIFO is non-empty. Push and pop in the same cycle leave count unchanged.
//   Pointers wrap modulo DEPTH. Count range is 0..DEPTH.
//   Push while full is ignored; IN_Ready=0, so it is also a protocol error.
//   FSM states: IDLE, ISSUE, WAIT.
//     IDLE  -> ISSUE: FIFO non-empty. Pop the head and register A, B, ALU_FUN.
//     ISSUE: exactly one enable high, decoded from IN_FUN[3:2]. Lasts 1 cycle, then WAIT.
//       The timeout counter clears on entry.
//     WAIT: Unit_Flag=1 -> Op_Done=1 next cycle, state IDLE.
//       Otherwise increment the counter; on reaching TIMEOUT, set Timeout_Err and go to IDLE. No Op_Done.
//   Unit_Flag outside WAIT is ignored.
//   All enables are 0 outside ISSUE. A, B, ALU_FUN hold their last issued values (0 after reset).
//   Latency: command pushed at edge t -> enable high during cycle t+1..t+2.
//     With an immediate flag, Op_Done is high during t+3..t+4.
//     Back-to-back issue interval is 3 cycles.
//   Commands issue strictly in FIFO order. Timeout_Err does not block further issue.
// TESTING
//   1 Reset: RST=1 for 2 cycles -> all enables 0, IN_Ready=1, Busy=0, Timeout_Err=0.
//   2 Single shift op: IN_A=16'h8001, IN_FUN=4'b1101, flag one cycle after enable
//     -> Shift_Enable 1 cycle, A=16'h8001, ALU_FUN=2'b01, Op_Done 3 cycles after push edge.
//   3 Fill: push 5 cmds with no pops (hold Unit_Flag=0, first in WAIT)
//     -> IN_Ready=0 after 4 stored; 5th accepted only after a pop.
//   4 Order: push arith, logic, cmp, shift back-to-back
//     -> enables pulse in that order, exactly one per 3 cycles, never two high together.
//   5 Timeout: Unit_Flag stuck 0, TIMEOUT=8
//     -> Timeout_Err set after 8 WAIT cycles, no Op_Done, next command still issues.
//   6 Reset in WAIT with 2 cmds queued, Unit_Flag=1 during RST
//     -> no Op_Done, FIFO empty, Busy=0, no further enables.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU command FIFO plus single-outstanding issue/wait sequencer
module alu_issue_ctrl #(
  parameter int Width   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_Valid,
  output logic             IN_Ready,
  input  logic [Width-1:0] IN_A,
  input  logic [Width-1:0] IN_B,
  input  logic [3:0]       IN_FUN,
  output logic [Width-1:0] A,
  output logic [Width-1:0] B,
  output logic [1:0]       ALU_FUN,
  output logic             Arith_Enable,
  output logic             Logic_Enable,
  output logic             CMP_Enable,
  output logic             Shift_Enable,
  input  logic             Unit_Flag,
  output logic             Op_Done,
  output logic             Timeout_Err,
  output logic             Busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  logic [Width-1:0] fifo_a [DEPTH];
  logic [Width-1:0] fifo_b [DEPTH];
  logic [3:0]       fifo_f [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [TW-1:0]    tmo_cnt;
  logic             push;
  logic             pop;

  // Ready looks only at the stored count, so a slot freed by a same-edge pop is not reused.
  assign IN_Ready = (count != CW'(DEPTH));
  assign push     = IN_Valid && IN_Ready;
  assign pop      = (state == IDLE) && (count != '0);
  assign Busy     = (count != '0) || (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      tmo_cnt      <= '0;
      A            <= '0;
      B            <= '0;
      ALU_FUN      <= '0;
      Arith_Enable <= 1'b0;
      Logic_Enable <= 1'b0;
      CMP_Enable   <= 1'b0;
      Shift_Enable <= 1'b0;
      Op_Done      <= 1'b0;
      Timeout_Err  <= 1'b0;
    end else begin
      if (push) begin
        fifo_a[wr_ptr] <= IN_A;
        fifo_b[wr_ptr] <= IN_B;
        fifo_f[wr_ptr] <= IN_FUN;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      Arith_Enable <= 1'b0;
      Logic_Enable <= 1'b0;
      CMP_Enable   <= 1'b0;
      Shift_Enable <= 1'b0;
      Op_Done      <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            A       <= fifo_a[rd_ptr];
            B       <= fifo_b[rd_ptr];
            ALU_FUN <= fifo_f[rd_ptr][1:0];
            case (fifo_f[rd_ptr][3:2])
              2'b00:   Arith_Enable <= 1'b1;
              2'b01:   Logic_Enable <= 1'b1;
              2'b10:   CMP_Enable   <= 1'b1;
              default: Shift_Enable <= 1'b1;
            endcase
            state <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (Unit_Flag) begin
            Op_Done <= 1'b1;
            state   <= IDLE;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            tmo_cnt     <= tmo_cnt + 1'b1;
            Timeout_Err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized and directed checks of alu_issue_ctrl against a transaction model
module tb_alu_issue_ctrl;

  localparam int W    = 16;
  localparam int DEP  = 4;
  localparam int TMO  = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IN_Valid;
  logic          IN_Ready;
  logic [W-1:0]  IN_A;
  logic [W-1:0]  IN_B;
  logic [3:0]    IN_FUN;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [1:0]    ALU_FUN;
  logic          Arith_Enable;
  logic          Logic_Enable;
  logic          CMP_Enable;
  logic          Shift_Enable;
  logic          Unit_Flag;
  logic          Op_Done;
  logic          Timeout_Err;
  logic          Busy;

  alu_issue_ctrl #(.Width(W), .DEPTH(DEP), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .IN_Valid(IN_Valid), .IN_Ready(IN_Ready),
    .IN_A(IN_A), .IN_B(IN_B), .IN_FUN(IN_FUN), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable), .CMP_Enable(CMP_Enable),
    .Shift_Enable(Shift_Enable), .Unit_Flag(Unit_Flag), .Op_Done(Op_Done),
    .Timeout_Err(Timeout_Err), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   f;
  } cmd_t;

  // Transaction-level model: a queue of pending commands and the age of the
  // one in flight (-1 none, 0 issue cycle, >=1 cycles spent waiting for the flag).
  cmd_t         q[$];
  int           age;
  int           waited;
  logic [W-1:0] m_a, m_b;
  logic [1:0]   m_fun;
  logic [3:0]   m_en;
  logic         m_done, m_err;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    age = -1; waited = 0;
    m_a = '0; m_b = '0; m_fun = '0; m_en = '0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] f, input logic fl, input logic r);
    bit   accept;
    cmd_t c;
    if (r) begin
      model_reset();
      return;
    end
    accept = v && (q.size() < DEP);
    m_en   = '0;
    m_done = 1'b0;
    if (age < 0) begin
      if (q.size() > 0) begin
        c = q.pop_front();
        m_a = c.a; m_b = c.b; m_fun = c.f[1:0];
        m_en = 4'b0001 << c.f[3:2];
        age = 0;
      end
    end else if (age == 0) begin
      age = 1; waited = 0;
    end else if (fl) begin
      m_done = 1'b1; age = -1;
    end else begin
      waited++;
      if (waited == TMO) begin
        m_err = 1'b1; age = -1;
      end
    end
    if (accept) begin
      c.a = a; c.b = b; c.f = f;
      q.push_back(c);
    end
  endtask

  task automatic compare_all();
    logic [3:0] en;
    en = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
    chk("enables", en, m_en);
    chk("one_hot", ($countones(en) <= 1), 1);
    chk("A", A, m_a);
    chk("B", B, m_b);
    chk("ALU_FUN", ALU_FUN, m_fun);
    chk("Op_Done", Op_Done, m_done);
    chk("Timeout_Err", Timeout_Err, m_err);
    chk("IN_Ready", IN_Ready, (q.size() < DEP));
    chk("Busy", Busy, (q.size() > 0) || (age >= 0));
  endtask

  task automatic cyc(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [3:0] f, input logic fl, input logic r);
    IN_Valid = v; IN_A = a; IN_B = b; IN_FUN = f; Unit_Flag = fl; RST = r;
    @(posedge CLK);
    model_edge(v, a, b, f, fl, r);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic idle(input logic fl);
    cyc(1'b0, '0, '0, 4'h0, fl, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, '0, 4'h0, 1'b1, 1'b1);
    cyc(1'b0, '0, '0, 4'h0, 1'b1, 1'b1);
  endtask

  initial begin
    model_reset();
    IN_Valid = 0; IN_A = '0; IN_B = '0; IN_FUN = '0; Unit_Flag = 0; RST = 1;

    do_reset();
    chk("rst_ready", IN_Ready, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_err", Timeout_Err, 0);

    // Single shift op, flag the cycle after the enable is sampled.
    cyc(1'b1, 16'h8001, 16'h0003, 4'b1101, 1'b0, 1'b0);
    idle(1'b0);
    chk("shift_en", Shift_Enable, 1);
    chk("shift_A", A, 16'h8001);
    chk("shift_fun", ALU_FUN, 2'b01);
    idle(1'b0);
    chk("shift_en_off", Shift_Enable, 0);
    idle(1'b1);
    chk("shift_done", Op_Done, 1);
    idle(1'b0);
    chk("shift_done_off", Op_Done, 0);

    // Fill with the first command stuck in WAIT.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, W'(i), W'(i + 16), 4'(i), 1'b0, 1'b0);
    chk("fill_ready_low", IN_Ready, 0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 16'hAAAA, 16'h5555, 4'h7, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b1);

    // Back-to-back order with immediate flags.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(i * 3), W'(i * 5), 4'(i * 4 + 2), 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) idle(1'b1);

    // Timeout with the flag held low, then a further command still issues.
    do_reset();
    cyc(1'b1, 16'h1234, 16'h4321, 4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) idle(1'b0);
    chk("tmo_not_yet", Timeout_Err, 0);
    idle(1'b0);
    chk("tmo_set", Timeout_Err, 1);
    chk("tmo_no_done", Op_Done, 0);
    cyc(1'b1, 16'h00FF, 16'h0F0F, 4'b0111, 1'b0, 1'b0);
    idle(1'b1);
    chk("tmo_next_issue", Logic_Enable, 1);
    chk("tmo_sticky", Timeout_Err, 1);
    idle(1'b1);
    idle(1'b1);

    // Reset while waiting with two commands queued.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, W'(i + 7), W'(i), 4'(i + 8), 1'b0, 1'b0);
    do_reset();
    chk("rstw_busy", Busy, 0);
    chk("rstw_done", Op_Done, 0);
    chk("rstw_ready", IN_Ready, 1);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 3) != 0, W'($urandom), W'($urandom), 4'($urandom),
          ($urandom % 4) != 0, ($urandom % 100) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
